// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states
// and the access-legality helpers used by the top level.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Stores only have signed-width encodings; loads also allow the unsigned forms.
  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    if (we) return !(funct3 inside {F3_B, F3_H, F3_W});
    return !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables / data replication and load lane
// extraction with sign or zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    be_o        = 4'b0000;
    wdata_rep_o = 32'h0;
    case (funct3_i[1:0])
      2'b00: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_rep_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_rep_o = {2{wdata_i[15:0]}};
      end
      default: begin
        be_o        = 4'b1111;
        wdata_rep_o = wdata_i;
      end
    endcase
  end

  assign sel_byte = rword_i[{addr_lo_i, 3'b000} +: 8];
  assign sel_half = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

  always_comb begin
    rdata_o = rword_i;
    case (funct3_i)
      F3_B:    rdata_o = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   rdata_o = {24'h0, sel_byte};
      F3_H:    rdata_o = {{16{sel_half[15]}}, sel_half};
      F3_HU:   rdata_o = {16'h0, sel_half};
      default: rdata_o = rword_i;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle RV32I data-memory target: valid/ready request, fixed latency,
// held response with back-pressure, byte-lane memory.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [AW+1:0] addr_q;
  logic [31:0] wdata_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [AW-1:0] word_idx;
  logic [31:0] rd_word;
  logic [31:0] load_data;
  logic [31:0] rdata_d;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic        access_err;
  logic        fire;
  logic        wr_en;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:AW+2];

  assign word_idx   = addr_q[AW+1:2];
  assign access_err = is_illegal(we_q, f3_q) || is_misaligned(f3_q, addr_q[1:0]);
  assign fire       = (state_q == WAIT) && (cnt_q == 4'd0);
  // Gate on reset_n so a store whose access edge coincides with reset is dropped.
  assign wr_en      = reset_n && fire && we_q && !access_err;
  assign rdata_d    = (we_q || access_err) ? 32'h0 : load_data;

  dmem_lane_align u_align (
    .funct3_i    (f3_q),
    .addr_lo_i   (addr_q[1:0]),
    .wdata_i     (wdata_q),
    .rword_i     (rd_word),
    .be_o        (be),
    .wdata_rep_o (wdata_rep),
    .rdata_o     (load_data)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (wr_en && be[gi]) lane_mem[word_idx] <= wdata_rep[gi*8 +: 8];
    end

    assign rd_word[gi*8 +: 8] = lane_mem[word_idx];
  end

  // Every transaction passes through WAIT so the response always lands
  // exactly LATENCY edges after accept, including LATENCY=1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          f3_q    <= req_funct3;
          addr_q  <= req_addr[AW+1:0];
          wdata_q <= req_wdata;
          cnt_q   <= 4'(LATENCY - 1);
          state_q <= WAIT;
        end
        WAIT: if (cnt_q == 4'd0) begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= rdata_d;
          rsp_err_q   <= access_err;
          state_q     <= RESP;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = reset_n && (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized bench for dmem_responder against a byte-addressed
// reference memory with RV32I load/store rules.
module tb_dmem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;

  logic [7:0] ref_mem [bit [31:0]];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: memory as bytes, addresses wrap at DEPTH*4 bytes.
  function automatic void ref_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, output logic [31:0] rd, output bit er);
    int size;
    bit legal;
    logic [31:0] val, a, mask;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    er    = !legal || ((addr % size) != 0);
    rd    = 32'h0;
    if (er) return;
    if (we) begin
      for (int i = 0; i < size; i++) begin
        a = (addr + i) % (DEPTH * 4);
        ref_mem[a] = wd[8*i +: 8];
      end
      return;
    end
    val = 32'h0;
    for (int i = 0; i < size; i++) begin
      a = (addr + i) % (DEPTH * 4);
      val = val | (32'(ref_mem.exists(a) ? ref_mem[a] : 8'h00) << (8 * i));
    end
    if (size < 4 && !f3[2] && val[8*size-1]) begin
      mask = (32'h1 << (8 * size)) - 1;
      val  = val | ~mask;
    end
    rd = val;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the response handshake.
  task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input int hold, input string tag);
    logic [31:0] exp_rd;
    bit exp_er;
    int lat;
    for (int n = 0; n < 20 && !req_ready; n++) begin @(posedge clk); #1; end
    chk({tag, "/ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    ref_txn(we, f3, addr, wd, exp_rd, exp_er);
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk({tag, "/latency"}, 32'(lat), 32'(LAT));
    chk({tag, "/rdata"}, rsp_rdata, exp_rd);
    chk({tag, "/err"}, 32'(rsp_err), 32'(exp_er));
    chk({tag, "/ready_in_resp"}, 32'(req_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, "/hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "/hold_rdata"}, rsp_rdata, exp_rd);
      chk({tag, "/hold_err"}, 32'(rsp_err), 32'(exp_er));
      chk({tag, "/hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "/post_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "/post_ready"}, 32'(req_ready), 32'd1);
    txn_no++;
    $display("txn %0d %s we=%0d f3=%0d addr=%h wdata=%h exp_rdata=%h exp_err=%0d lat=%0d",
             txn_no, tag, we, f3, addr, wd, exp_rd, exp_er, lat);
  endtask

  initial begin
    // Reset
    reset_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("reset/ready_low", 32'(req_ready), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("reset/ready", 32'(req_ready), 32'd1);
    chk("reset/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset/rsp_rdata", rsp_rdata, 32'd0);
    chk("reset/rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk); #1;

    // Word round-trip
    txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, "sw10");
    txn(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw10");

    // Sub-word loads
    txn(1'b1, 3'b010, 32'h20, 32'h804000F0, 0, "sw20");
    txn(1'b0, 3'b000, 32'h20, 32'h0, 0, "lb20");
    txn(1'b0, 3'b100, 32'h20, 32'h0, 0, "lbu20");
    txn(1'b0, 3'b001, 32'h22, 32'h0, 0, "lh22");
    txn(1'b0, 3'b101, 32'h22, 32'h0, 0, "lhu22");
    txn(1'b1, 3'b000, 32'h21, 32'h000000AB, 0, "sb21");
    txn(1'b0, 3'b010, 32'h20, 32'h0, 0, "lw20");

    // Misaligned and illegal
    txn(1'b1, 3'b010, 32'h13, 32'h11223344, 0, "sw13_mis");
    txn(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw10_again");
    txn(1'b0, 3'b001, 32'h21, 32'h0, 0, "lh21_mis");
    txn(1'b0, 3'b011, 32'h20, 32'h0, 0, "ld_f3_011");
    txn(1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, 0, "st_f3_100");
    txn(1'b0, 3'b010, 32'h20, 32'h0, 0, "lw20_again");

    // Back-pressure
    txn(1'b0, 3'b010, 32'h10, 32'h0, 5, "lw10_bp");

    // Reset while a store is in WAIT
    txn(1'b1, 3'b010, 32'h40, 32'h55AA55AA, 0, "sw40_prior");
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst/ready_low", 32'(req_ready), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b1;
    #1;
    chk("midrst/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst/ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    txn(1'b0, 3'b010, 32'h40, 32'h0, 0, "lw40_after_rst");

    // Address wrap
    txn(1'b1, 3'b010, 32'h1000, 32'h13579BDF, 0, "sw1000");
    txn(1'b0, 3'b010, 32'h0, 32'h0, 0, "lw0_wrap");

    // Randomized traffic over an initialised window
    for (int a = 32'h100; a < 32'h140; a += 4)
      txn(1'b1, 3'b010, 32'(a), $urandom, 0, "init");
    for (int i = 0; i < 40; i++)
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          32'h100 + 32'($urandom_range(0, 63)), $urandom, $urandom_range(0, 3), "rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
